serial_bus_unit: RTL
====================

# serial_bus_unit

Parametrised serial bus interface between the CPU core and the external microcontroller on the narrow byte bus. It replaces fixed per-register serial shift-out paths with one arbitrated serializer for N_CH parallel source channels (e.g. PC, MDR, MAR). It adds a deserializer with an RX word FIFO for inbound instruction and data words. It has back-pressured handshakes in both directions and sticky error flags.

## Interface
Parameters:
- DATA_W, 16, word width; must be a multiple of BUS_W
- BUS_W, 8, bus beat width; BEATS = DATA_W/BUS_W, must be ≥1
- N_CH, 3, number of TX source channels, ≥1
- RX_DEPTH, 4, RX FIFO depth in words, power of two, ≥2

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tx_load  in  N_CH  per-channel capture strobe
- tx_data  in  N_CH×DATA_W  per-channel parallel word
- tx_busy  out  N_CH  channel word pending or being shifted
- out_bus  out  BUS_W  current TX beat
- out_valid  out  1  out_bus holds a valid beat
- ard_receive_ready  in  1  external side accepts the beat this cycle
- bus_sel  out  N_CH  one-hot granted channel; 0 when idle
- in_bus  in  BUS_W  inbound beat
- ard_data_ready  in  1  in_bus valid this cycle
- rx_flush  in  1  discard partial inbound word
- rx_word  out  DATA_W  FIFO head word
- rx_valid  out  1  FIFO non-empty
- rx_pop  in  1  consume head word
- rx_count  out  $clog2(RX_DEPTH)+1  words held
- err_tx_collide  out  1  sticky: tx_load hit a busy channel
- err_rx_overflow  out  1  sticky: word dropped on full FIFO
- err_clr  in  1  clears both sticky errors

## Operation
- Each channel has a holding register and a pending flag.
- tx_load[i] with pending[i]=0 captures tx_data[i] and sets pending[i].
- tx_load[i] with pending[i]=1 is ignored. The held word is kept and err_tx_collide is set.
- tx_busy = pending.
- TX FSM states: IDLE and SHIFT.
  - IDLE: if any pending, grant round-robin starting from last_grant+1. Load the shift register, set bus_sel, reset the beat count, and go to SHIFT.
  - SHIFT: out_valid=1 and out_bus = most-significant beat.
  - On out_valid & ard_receive_ready, shift left by BUS_W and increment the beat count.
  - On acceptance of beat BEATS-1: clear the granted pending flag, update last_grant, clear bus_sel, and return to IDLE.
- out_bus is 0 whenever out_valid=0.
- RX: each ard_data_ready cycle shifts in_bus into the assembly register, MS beat first.
- On the BEATS-th beat, the word is pushed to the FIFO and the beat count wraps to 0.
- Push when full and no pop that cycle: word dropped, err_rx_overflow set. Push when full with rx_pop succeeds.
- rx_pop while empty is ignored.
- rx_flush zeroes the RX beat count. It wins over a same-cycle beat, and that beat is discarded. FIFO contents are unaffected.
- err_clr clears both errors. An error event in the same cycle wins, and the flag stays set.

## Timing
- Reset: all outputs 0, FSM IDLE, pending 0, FIFO empty, RX beat count 0, last_grant = N_CH-1 (channel 0 granted first).
- rst mid-word aborts TX and RX immediately. No partial beats or words survive.
- tx_load at edge k: tx_busy high after k. First out_valid is high after edge k+1, if the FSM is idle and the channel wins.
- A word occupies BEATS cycles at full ready plus one IDLE bubble before the next grant.
- ard_receive_ready low stalls with out_bus/bus_sel stable.
- A tx_load on another channel during SHIFT does not disturb the active transfer.
- RX: the last beat at edge k makes rx_valid/rx_word visible after edge k, with 1-cycle latency.
- rx_count updates at the same edge.

## Structure
- Shared package: bus_tx_state_t enum (IDLE, SHIFT) and a BEATS-derivation helper constant.
- One sub-module: word_fifo (synchronous FIFO, parameters DATA_W and RX_DEPTH, push/pop/full/empty/count). Instantiated once for RX.

## Test plan
Defaults: DATA_W=16, BUS_W=8, N_CH=3, RX_DEPTH=4.
- Single TX: load ch1=16'hA55A, ready held high → beats 8'hA5 then 8'h5A, bus_sel=3'b010, tx_busy[1] drops after second beat.
- Round-robin: load ch0=16'h1111, ch1=16'h2222, ch2=16'h3333 in the same cycle → words emitted in order ch0, ch1, ch2, one bubble between words. Reloading ch0 then ch2 while ch1 is active → ch2 is served before ch0.
- Back-pressure and collision: ready low 5 cycles mid-word → out_bus held at 8'hBE for word 16'hBEEF. tx_load on the busy channel with 16'h0000 → 16'hBEEF still sent, err_tx_collide=1. err_clr → 0.
- RX and overflow: 10 beats 01..0A, no pop → FIFO holds 0x0102, 0x0304, 0x0506, 0x0708, rx_count=4. 0x090A is dropped and err_rx_overflow=1. Then the full-FIFO push-with-pop case → accepted, count stays 4.
- Flush and reset: one beat 8'hFF then rx_flush, then 8'h12, 8'h34 → rx_word=16'h1234. rst asserted mid-TX → out_valid, bus_sel and tx_busy are 0 the next cycle.

Source files
------------

// File: rtl/serial_bus_unit_pkg.sv
// serial_bus_unit shared types and helpers.
// Imported by the serializer/deserializer top.
package serial_bus_unit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bus_tx_state_t;

  function automatic int beats_of(
    input int data_w,
    input int bus_w
  );
    return data_w / bus_w;
  endfunction

  localparam int BEATS_DEF = beats_of(16, 8);

endpackage

// File: rtl/serial_bus_unit_if.sv
// Narrow byte bus between the core and the external controller.
// master = core side, slave = external side.
interface serial_bus_unit_if #(
  parameter int BUS_W = 8,
  parameter int N_CH  = 3
);

  logic [BUS_W-1:0] out_bus;
  logic             out_valid;
  logic             ard_receive_ready;
  logic [N_CH-1:0]  bus_sel;
  logic [BUS_W-1:0] in_bus;
  logic             ard_data_ready;

  modport master (
    output out_bus,
    output out_valid,
    output bus_sel,
    input  ard_receive_ready,
    input  in_bus,
    input  ard_data_ready
  );

  modport slave (
    input  out_bus,
    input  out_valid,
    input  bus_sel,
    output ard_receive_ready,
    output in_bus,
    output ard_data_ready
  );

endinterface

// File: rtl/serial_bus_unit_word_fifo.sv
// Synchronous word FIFO; push on full succeeds only with a pop.
// Head reads as zero while empty.
module word_fifo #(
  parameter int DATA_W   = 16,
  parameter int RX_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(RX_DEPTH):0] count
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [RX_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(RX_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_bus_unit.sv
// Arbitrated N-channel word serializer plus beat deserializer
// with an RX word FIFO and sticky error flags.
module serial_bus_unit
  import serial_bus_unit_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int BUS_W    = 8,
  parameter int N_CH     = 3,
  parameter int RX_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0]              tx_load,
  input  logic [N_CH-1:0][DATA_W-1:0]  tx_data,
  output logic [N_CH-1:0]              tx_busy,
  serial_bus_unit_if.master            bus,
  input  logic                         rx_flush,
  output logic [DATA_W-1:0]            rx_word,
  output logic                         rx_valid,
  input  logic                         rx_pop,
  output logic [$clog2(RX_DEPTH):0]    rx_count,
  output logic                         err_tx_collide,
  output logic                         err_rx_overflow,
  input  logic                         err_clr
);

  localparam int BEATS = beats_of(DATA_W, BUS_W);
  localparam int TW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [TW-1:0] LAST_BEAT = TW'(BEATS - 1);
  localparam logic [GW-1:0] LAST_CH   = GW'(N_CH - 1);

  bus_tx_state_t state;
  bus_tx_state_t state_nx;

  logic [N_CH-1:0]   pending;
  logic [DATA_W-1:0] hold [N_CH];
  logic [DATA_W-1:0] sh_q;
  logic [TW-1:0]     beat_q;
  logic [N_CH-1:0]   sel_q;
  logic [GW-1:0]     act_q;
  logic [GW-1:0]     last_q;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     cand;
  logic              found;
  int                j;

  logic load_sh;
  logic adv;
  logic done;
  logic collide;

  assign tx_busy       = pending;
  assign bus.bus_sel   = sel_q;
  assign bus.out_valid = (state == SHIFT);
  assign bus.out_bus   = bus.out_valid
                       ? sh_q[DATA_W-1 -: BUS_W]
                       : '0;
  assign collide       = |(tx_load & pending);

  // Round-robin search starting just after the last served channel.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      j    = (int'(last_q) + k) % N_CH;
      cand = GW'(j);
      if (!found && pending[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_sh  = 1'b0;
    adv      = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          load_sh  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ard_receive_ready) begin
          adv = 1'b1;
          if (beat_q == LAST_BEAT) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      beat_q <= '0;
      sel_q  <= '0;
      act_q  <= '0;
      last_q <= LAST_CH;
    end else if (load_sh) begin
      sh_q   <= hold[grant];
      beat_q <= '0;
      sel_q  <= N_CH'(1) << grant;
      act_q  <= grant;
    end else if (adv) begin
      sh_q   <= sh_q << BUS_W;
      beat_q <= beat_q + 1'b1;
      if (done) begin
        beat_q <= '0;
        sel_q  <= '0;
        last_q <= act_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (done) pending[act_q] <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (tx_load[i] && !pending[i]) pending[i] <= 1'b1;
      end
    end
  end

  // A held word is never overwritten while its channel is pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (tx_load[i] && !pending[i]) hold[i] <= tx_data[i];
    end
  end

  logic [TW-1:0]     rx_beat;
  logic [DATA_W-1:0] rx_asm;
  logic [DATA_W-1:0] rx_next;
  logic              rx_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;

  assign rx_next  = (rx_asm << BUS_W) | DATA_W'(bus.in_bus);
  assign rx_push  = bus.ard_data_ready && !rx_flush
                 && (rx_beat == LAST_BEAT);
  assign overflow = rx_push && fifo_full && !rx_pop;
  assign rx_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_beat <= '0;
      rx_asm  <= '0;
    end else if (rx_flush) begin
      rx_beat <= '0;
    end else if (bus.ard_data_ready) begin
      rx_asm  <= rx_next;
      rx_beat <= rx_push ? '0 : rx_beat + 1'b1;
    end
  end

  word_fifo #(
    .DATA_W   (DATA_W),
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_next),
    .rdata (rx_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  // An error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_tx_collide  <= 1'b0;
      err_rx_overflow <= 1'b0;
    end else begin
      if (collide)      err_tx_collide <= 1'b1;
      else if (err_clr) err_tx_collide <= 1'b0;
      if (overflow)     err_rx_overflow <= 1'b1;
      else if (err_clr) err_rx_overflow <= 1'b0;
    end
  end

endmodule
